// File: rtl/risc_datapath.sv
// Execution datapath for the simple RISC machine: 8x16 register file, A/B operand
// latches, B-side shifter, 4-function ALU, result register C and zero flag.

module risc_regfile (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write,
  input  logic [2:0]  writenum,
  input  logic [2:0]  readnum,
  input  logic [15:0] data_in,
  output logic [15:0] data_out
);

  // Kept as discrete registers so R0..R7 can be reached by name from a bench.
  logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      R0 <= '0;
      R1 <= '0;
      R2 <= '0;
      R3 <= '0;
      R4 <= '0;
      R5 <= '0;
      R6 <= '0;
      R7 <= '0;
    end else if (write) begin
      case (writenum)
        3'd0: R0 <= data_in;
        3'd1: R1 <= data_in;
        3'd2: R2 <= data_in;
        3'd3: R3 <= data_in;
        3'd4: R4 <= data_in;
        3'd5: R5 <= data_in;
        3'd6: R6 <= data_in;
        default: R7 <= data_in;
      endcase
    end
  end

  // Read sees stored values only; a same-cycle write shows up after the edge.
  always_comb begin
    data_out = R0;
    case (readnum)
      3'd0: data_out = R0;
      3'd1: data_out = R1;
      3'd2: data_out = R2;
      3'd3: data_out = R3;
      3'd4: data_out = R4;
      3'd5: data_out = R5;
      3'd6: data_out = R6;
      default: data_out = R7;
    endcase
  end

endmodule

module risc_shifter (
  input  logic [15:0] in,
  input  logic [1:0]  shift,
  output logic [15:0] out
);

  always_comb begin
    out = in;
    case (shift)
      2'b00: out = in;
      2'b01: out = {in[14:0], 1'b0};
      2'b10: out = {1'b0, in[15:1]};
      default: out = {in[15], in[15:1]};
    endcase
  end

endmodule

module risc_alu (
  input  logic [15:0] ain,
  input  logic [15:0] bin,
  input  logic [1:0]  alu_op,
  output logic [15:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (alu_op)
      2'b00: result = ain + bin;
      2'b01: result = ain - bin;
      2'b10: result = ain & bin;
      default: result = ~bin;
    endcase
    zero = (result == 16'd0);
  end

endmodule

module risc_datapath (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] datapath_in,
  input  logic        vsel,
  input  logic [2:0]  writenum,
  input  logic        write,
  input  logic [2:0]  readnum,
  input  logic        loada,
  input  logic        loadb,
  input  logic [1:0]  shift,
  input  logic        asel,
  input  logic        bsel,
  input  logic [1:0]  ALUop,
  input  logic        loadc,
  input  logic        loads,
  output logic        Z_out,
  output logic [15:0] datapath_out
);

  logic [15:0] write_data;
  logic [15:0] read_data;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [15:0] c_reg;
  logic        status;
  logic [15:0] shift_out;
  logic [15:0] ain;
  logic [15:0] bin;
  logic [15:0] alu_result;
  logic        alu_zero;

  // Write-back of C uses the value held before this edge.
  assign write_data = vsel ? datapath_in : c_reg;

  risc_regfile REGFILE (
    .clk      (clk),
    .reset_n  (reset_n),
    .write    (write),
    .writenum (writenum),
    .readnum  (readnum),
    .data_in  (write_data),
    .data_out (read_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      c_reg  <= '0;
      status <= 1'b0;
    end else begin
      if (loada) a_reg  <= read_data;
      if (loadb) b_reg  <= read_data;
      if (loadc) c_reg  <= alu_result;
      if (loads) status <= alu_zero;
    end
  end

  risc_shifter u_shifter (
    .in    (b_reg),
    .shift (shift),
    .out   (shift_out)
  );

  assign ain = asel ? 16'd0 : a_reg;
  assign bin = bsel ? {11'b0, datapath_in[4:0]} : shift_out;

  risc_alu u_alu (
    .ain    (ain),
    .bin    (bin),
    .alu_op (ALUop),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign datapath_out = c_reg;
  assign Z_out        = status;

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath: register write-back, shift/ALU paths, zero
// flag, same-edge enable interactions and synchronous reset mid-operation.

module tb_risc_datapath;

  logic        clk;
  logic        reset_n;
  logic [15:0] datapath_in;
  logic        vsel;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum;
  logic        loada;
  logic        loadb;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic        Z_out;
  logic [15:0] datapath_out;

  int checks = 0;
  int errors = 0;

  risc_datapath dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .datapath_in  (datapath_in),
    .vsel         (vsel),
    .writenum     (writenum),
    .write        (write),
    .readnum      (readnum),
    .loada        (loada),
    .loadb        (loadb),
    .shift        (shift),
    .asel         (asel),
    .bsel         (bsel),
    .ALUop        (ALUop),
    .loadc        (loadc),
    .loads        (loads),
    .Z_out        (Z_out),
    .datapath_out (datapath_out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1ns after the rising edge, outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    datapath_in = '0; vsel = 0; writenum = '0; write = 0; readnum = '0;
    loada = 0; loadb = 0; shift = '0; asel = 0; bsel = 0; ALUop = '0;
    loadc = 0; loads = 0;
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
    idle();
    vsel = 1; write = 1; writenum = idx; datapath_in = val;
    tick();
    idle();
  endtask

  task automatic load_a(input logic [2:0] idx);
    idle();
    readnum = idx; loada = 1;
    tick();
    idle();
  endtask

  task automatic load_b(input logic [2:0] idx);
    idle();
    readnum = idx; loadb = 1;
    tick();
    idle();
  endtask

  task automatic exec(input logic a_s, input logic b_s, input logic [1:0] sh,
                      input logic [1:0] op, input logic [15:0] din);
    idle();
    asel = a_s; bsel = b_s; shift = sh; ALUop = op; datapath_in = din;
    loadc = 1; loads = 1;
    tick();
    idle();
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3,
                            input logic [15:0] e4, input logic [15:0] e5,
                            input logic [15:0] e6, input logic [15:0] e7);
    check16({tag, "_r0"}, dut.REGFILE.R0, e0);
    check16({tag, "_r1"}, dut.REGFILE.R1, e1);
    check16({tag, "_r2"}, dut.REGFILE.R2, e2);
    check16({tag, "_r3"}, dut.REGFILE.R3, e3);
    check16({tag, "_r4"}, dut.REGFILE.R4, e4);
    check16({tag, "_r5"}, dut.REGFILE.R5, e5);
    check16({tag, "_r6"}, dut.REGFILE.R6, e6);
    check16({tag, "_r7"}, dut.REGFILE.R7, e7);
  endtask

  initial begin
    idle();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;

    // Reset state
    check16("reset_c", datapath_out, 16'h0000);
    check1("reset_z", Z_out, 1'b0);
    check_regs("reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Input write-back
    write_reg(3'd0, 16'd7);
    write_reg(3'd1, 16'd2);
    check_regs("wb_in", 16'd7, 16'd2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Shift-add: 2 + (7<<1) = 16, then write C back to R2
    load_a(3'd1);
    load_b(3'd0);
    exec(1'b0, 1'b0, 2'b01, 2'b00, 16'h0);
    check16("shadd_c", datapath_out, 16'd16);
    check1("shadd_z", Z_out, 1'b0);
    vsel = 0; writenum = 3'd2; write = 1;
    tick();
    idle();
    check_regs("wb_c", 16'd7, 16'd2, 16'd16, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Subtract to zero, then 5-3
    write_reg(3'd3, 16'd5);
    load_a(3'd3);
    load_b(3'd3);
    exec(1'b0, 1'b0, 2'b00, 2'b01, 16'h0);
    check16("sub0_c", datapath_out, 16'h0000);
    check1("sub0_z", Z_out, 1'b1);
    write_reg(3'd4, 16'd3);
    load_b(3'd4);
    exec(1'b0, 1'b0, 2'b00, 2'b01, 16'h0);
    check16("sub2_c", datapath_out, 16'd2);
    check1("sub2_z", Z_out, 1'b0);

    // Shifter modes on B = 8001 through 0 + Bin
    write_reg(3'd5, 16'h8001);
    load_b(3'd5);
    exec(1'b1, 1'b0, 2'b00, 2'b00, 16'h0);
    check16("sh00", datapath_out, 16'h8001);
    exec(1'b1, 1'b0, 2'b10, 2'b00, 16'h0);
    check16("sh10", datapath_out, 16'h4000);
    exec(1'b1, 1'b0, 2'b11, 2'b00, 16'h0);
    check16("sh11", datapath_out, 16'hC000);
    exec(1'b1, 1'b0, 2'b01, 2'b00, 16'h0);
    check16("sh01", datapath_out, 16'h0002);

    // Immediate path uses only datapath_in[4:0]
    exec(1'b1, 1'b1, 2'b00, 2'b00, 16'hFFF3);
    check16("imm_c", datapath_out, 16'h0013);

    // NOT and AND
    write_reg(3'd6, 16'h00FF);
    load_b(3'd6);
    exec(1'b0, 1'b0, 2'b00, 2'b11, 16'h0);
    check16("not_c", datapath_out, 16'hFF00);
    load_a(3'd5);
    exec(1'b0, 1'b0, 2'b00, 2'b10, 16'h0);
    check16("and_c", datapath_out, 16'h0001);
    check1("and_z", Z_out, 1'b0);

    // Wraparound FFFF + 1
    write_reg(3'd7, 16'hFFFF);
    load_a(3'd7);
    exec(1'b0, 1'b1, 2'b00, 2'b00, 16'h0001);
    check16("wrap_c", datapath_out, 16'h0000);
    check1("wrap_z", Z_out, 1'b1);

    // loadc and C write-back on the same edge: R3 gets old C (0), C becomes 1
    idle();
    asel = 0; bsel = 1; datapath_in = 16'h0002; ALUop = 2'b00; loadc = 1;
    vsel = 0; writenum = 3'd3; write = 1;
    tick();
    idle();
    check16("same_edge_r3", dut.REGFILE.R3, 16'h0000);
    check16("same_edge_c", datapath_out, 16'h0001);

    // Read and write same register with loada: A takes the old value (2)
    idle();
    readnum = 3'd1; loada = 1; writenum = 3'd1; write = 1; vsel = 1;
    datapath_in = 16'h1234;
    tick();
    idle();
    check16("rw_r1", dut.REGFILE.R1, 16'h1234);
    exec(1'b0, 1'b1, 2'b00, 2'b00, 16'h0000);
    check16("rw_old_a", datapath_out, 16'd2);

    // Reset overrides write/loadc/loads on the same edge
    load_b(3'd5);
    idle();
    reset_n = 0;
    vsel = 1; write = 1; writenum = 3'd0; datapath_in = 16'hAAAA;
    readnum = 3'd7; loada = 1; loadb = 1;
    ALUop = 2'b11; loadc = 1; loads = 1;
    tick();
    idle();
    reset_n = 1;
    check16("rst_mid_c", datapath_out, 16'h0000);
    check1("rst_mid_z", Z_out, 1'b0);
    check_regs("rst_mid", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    // ~B = FFFF shows B cleared; A - B = 0 then shows A cleared
    exec(1'b0, 1'b0, 2'b00, 2'b11, 16'h0);
    check16("rst_b", datapath_out, 16'hFFFF);
    check1("rst_b_z", Z_out, 1'b0);
    exec(1'b0, 1'b0, 2'b00, 2'b01, 16'h0);
    check16("rst_a", datapath_out, 16'h0000);
    check1("rst_a_z", Z_out, 1'b1);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_datapath.md
# risc_datapath

16-bit execution datapath for the simple RISC machine: an 8×16 register file, A/B operand latches, a 1-bit shifter on the B operand, a 4-function ALU, a result register C and a zero-status flag. All sequencing comes from external control signals (the controller FSM); the block itself holds no state machine. Result C is fed back as a write-back source and exported as `datapath_out`.

## Interface
- No parameters; data width fixed at 16, register count fixed at 8.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `datapath_in` input 16: external write-back data; bits [4:0] also form the immediate B operand.
- `vsel` input 1: write-back source select; 1 = `datapath_in`, 0 = `datapath_out` (C).
- `writenum` input 3: destination register index.
- `write` input 1: register-file write enable.
- `readnum` input 3: source register index (combinational read).
- `loada` input 1: load enable for register A.
- `loadb` input 1: load enable for register B.
- `shift` input 2: shifter op on B.
- `asel` input 1: 1 = ALU A input forced to 0; 0 = register A.
- `bsel` input 1: 1 = ALU B input is {11'b0, `datapath_in`[4:0]}; 0 = shifter output.
- `ALUop` input 2: ALU function.
- `loadc` input 1: load enable for result register C.
- `loads` input 1: load enable for status (Z) register.
- `Z_out` output 1: registered zero flag.
- `datapath_out` output 16: contents of register C.
- Register file is a submodule instance named `REGFILE` with 16-bit registers `R0`..`R7` accessible by hierarchical reference for verification.

## Operation
- Register file: read_data = R[`readnum`], combinational from stored values. On rising edge with `write`=1, R[`writenum`] <= `vsel` ? `datapath_in` : `datapath_out`.
- A <= read_data when `loada`=1; B <= read_data when `loadb`=1; otherwise hold.
- Shifter on B: 00 = B; 01 = B<<1 (LSB 0); 10 = B>>1 logical (MSB 0); 11 = B>>1 arithmetic (MSB replicated).
- Ain = `asel` ? 16'd0 : A. Bin = `bsel` ? {11'b0, `datapath_in`[4:0]} : shifter output.
- ALU: 00 = Ain+Bin; 01 = Ain−Bin; 10 = Ain & Bin; 11 = ~Bin. Results truncated to 16 bits (mod 2^16), no carry/overflow outputs.
- Z = (ALU result == 0). C <= ALU result when `loadc`=1; status <= Z when `loads`=1.
- `datapath_out` = C; `Z_out` = status.

## Timing
- Reset: on rising edge with `reset_n`=0, R0–R7, A, B, C and status cleared to 0; `datapath_out`=0, `Z_out`=0 the cycle after. Reset overrides every load/write enable in that cycle.
- Read of register file is same-cycle combinational; a write to the register being read is visible only after the edge (read returns old value before the edge).
- Latency: register → A/B 1 edge; A/B → C/status 1 edge (combinational shifter+ALU); C → register-file write-back 1 edge. Minimum register-to-register operation = 3 edges.
- Multiple enables in one cycle are independent; all registers sample on the same edge (e.g. `loadc` and `write` with `vsel`=0 writes the old C).
- `writenum`=`readnum` with `write`=1 and `loada`=1: A receives old register value.
- No handshake; controller guarantees stable controls before each edge.

## Test plan
- Write-back of input: `vsel`=1, `write`=1, load 7 into R0 then 2 into R1 -> R0=7, R1=2, others unchanged.
- Shift-add: A=R1 (2), B=R0 (7), shift=01, asel=0, bsel=0, ALUop=00, loadc=1 -> C=16; then vsel=0, writenum=2, write=1 -> R2=16, R0=7, R1=2.
- Subtract to zero with flag: A=B=5, ALUop=01, loadc=1, loads=1 -> `datapath_out`=0, `Z_out`=1; then A=5, B=3 -> C=2, Z_out=0.
- Shifter modes: B=16'h8001; shift 10 -> 16'h4000; shift 11 -> 16'hC000; shift 01 -> 16'h0002.
- asel/bsel/logic: asel=1, bsel=1, `datapath_in`=16'hFFF3, ALUop=00 -> C=16'h0013; ALUop=11 with bsel=0, B=16'h00FF, shift=00 -> C=16'hFF00; add 16'hFFFF+1 -> C=0 (wrap), Z=1.
- Reset mid-operation: load registers and C, assert `reset_n`=0 with `write`=1 and `loadc`=1 -> all R0–R7, A, B, C, status read 0 after the edge.
